// File: rtl/cpu_control_sequencer.sv
// cpu_control_sequencer: multi-cycle control unit for the datapath CPU.
// Sequences FETCH -> EXEC -> (MEM) -> FETCH and stalls on mem_ready.
// Handshake: mem_req is held high in FETCH/MEM until a cycle with mem_ready=1.
// That cycle completes the request, and the FSM leaves the state on the next edge.
// mem_ready is ignored in every other state.
// Optional feature macro: MEM_TIMEOUT_EN adds a wait counter, a FAULT state and the fault port.
// dbg_state exposes the FSM state encoding for checkers.
module cpu_control_sequencer #(
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 3,
    parameter int IMM_W   = 8,
    parameter int FS_W    = 5,
    parameter int TMO_CYC = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] IR,
    input  logic               mem_ready,
    input  logic               zero,
    output logic [1:0]         PS,
    output logic               IR_L,
    output logic [REG_AW-1:0]  AA,
    output logic [REG_AW-1:0]  BA,
    output logic [REG_AW-1:0]  DA,
    output logic               WR,
    output logic [FS_W-1:0]    FS,
    output logic               Cin,
    output logic [1:0]         MuxD,
    output logic               MuxA,
    output logic [DATA_W-1:0]  K,
    output logic               mem_req,
    output logic               MemWrite,
    output logic               halted,
`ifdef MEM_TIMEOUT_EN
    output logic               fault,
`endif
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_HALT  = 3'd3
`ifdef MEM_TIMEOUT_EN
        ,S_FAULT = 3'd4
`endif
    } state_t;

    localparam logic [2:0] C_NOP   = 3'b000;
    localparam logic [2:0] C_ALUI  = 3'b001;
    localparam logic [2:0] C_ALUR  = 3'b010;
    localparam logic [2:0] C_LOAD  = 3'b011;
    localparam logic [2:0] C_STORE = 3'b100;
    localparam logic [2:0] C_BRZ   = 3'b101;
    localparam logic [2:0] C_JMP   = 3'b110;
    localparam logic [2:0] C_HALT  = 3'b111;

    state_t state, state_nx;

    logic [2:0]        cls;
    logic [1:0]        sub;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [IMM_W-1:0]  imm;
    logic              tmo_hit;

    assign cls = IR[INSTR_W-1 -: 3];
    assign sub = IR[INSTR_W-4 -: 2];
    assign rd  = IR[INSTR_W-6 -: REG_AW];
    assign rs  = IR[INSTR_W-6-REG_AW -: REG_AW];
    assign imm = IR[IMM_W-1:0];

    assign dbg_state = state;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TMO_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Wait counter: cleared on any state change, counts stalled FETCH/MEM cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state_nx != state) begin
            wait_cnt <= '0;
        end else if ((state == S_FETCH || state == S_MEM) && !mem_ready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // The count reaches TMO_CYC this cycle with no completion; mem_ready wins a tie.
    assign tmo_hit = !mem_ready && (wait_cnt == CNT_W'(TMO_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Field decode: addresses, function select and immediate follow IR in every state.
    always_comb begin
        AA  = rd;
        DA  = rd;
        BA  = rs;
        FS  = '0;
        FS[1:0] = sub;
        Cin = (sub == 2'b01);
        K   = '0;
        if (cls == C_ALUI) begin
            K = {{(DATA_W-IMM_W){1'b0}}, imm};
        end else if (cls == C_BRZ || cls == C_JMP) begin
            K = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nx;
    end

    // Next-state and control strobes; all strobes forced low while in reset.
    always_comb begin
        state_nx = state;
        PS       = 2'b00;
        IR_L     = 1'b0;
        WR       = 1'b0;
        MuxD     = 2'b00;
        MuxA     = 1'b0;
        mem_req  = 1'b0;
        MemWrite = 1'b0;
        halted   = 1'b0;
`ifdef MEM_TIMEOUT_EN
        fault    = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IR_L     = 1'b1;
                    PS       = 2'b01;
                    state_nx = S_EXEC;
                end else if (tmo_hit) begin
`ifdef MEM_TIMEOUT_EN
                    state_nx = S_FAULT;
`endif
                end
            end
            S_EXEC: begin
                state_nx = S_FETCH;
                case (cls)
                    C_NOP:   ;
                    C_ALUI,
                    C_ALUR:  WR = 1'b1;
                    C_LOAD,
                    C_STORE: state_nx = S_MEM;
                    C_BRZ:   PS = zero ? 2'b10 : 2'b00;
                    C_JMP:   PS = 2'b11;
                    C_HALT:  state_nx = S_HALT;
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                MuxA    = 1'b1;
                if (mem_ready) begin
                    if (cls == C_LOAD) begin
                        WR   = 1'b1;
                        MuxD = 2'b01;
                    end else begin
                        MemWrite = 1'b1;
                    end
                    state_nx = S_FETCH;
                end else if (tmo_hit) begin
`ifdef MEM_TIMEOUT_EN
                    state_nx = S_FAULT;
`endif
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
`ifdef MEM_TIMEOUT_EN
            S_FAULT: begin
                fault = 1'b1;
            end
`endif
            default: state_nx = S_FETCH;
        endcase

        if (!rst_n) begin
            state_nx = S_FETCH;
            PS       = 2'b00;
            IR_L     = 1'b0;
            WR       = 1'b0;
            MuxD     = 2'b00;
            MuxA     = 1'b0;
            mem_req  = 1'b0;
            MemWrite = 1'b0;
            halted   = 1'b0;
`ifdef MEM_TIMEOUT_EN
            fault    = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Directed bench for cpu_control_sequencer. Inputs change #1 after a rising edge.
// Outputs are checked after a further #1 settle.
// State encoding seen on dbg_state: 0 FETCH, 1 EXEC, 2 MEM, 3 HALT, 4 FAULT.
module tb_cpu_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] IR;
    logic        mem_ready;
    logic        zero;
    logic [1:0]  PS;
    logic        IR_L;
    logic [2:0]  AA, BA, DA;
    logic        WR;
    logic [4:0]  FS;
    logic        Cin;
    logic [1:0]  MuxD;
    logic        MuxA;
    logic [15:0] K;
    logic        mem_req;
    logic        MemWrite;
    logic        halted;
`ifdef MEM_TIMEOUT_EN
    logic        fault;
`endif
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    int pulses;

    cpu_control_sequencer dut (
        .clk(clk), .rst_n(rst_n), .IR(IR), .mem_ready(mem_ready), .zero(zero),
        .PS(PS), .IR_L(IR_L), .AA(AA), .BA(BA), .DA(DA), .WR(WR), .FS(FS),
        .Cin(Cin), .MuxD(MuxD), .MuxA(MuxA), .K(K), .mem_req(mem_req),
        .MemWrite(MemWrite), .halted(halted),
`ifdef MEM_TIMEOUT_EN
        .fault(fault),
`endif
        .dbg_state(dbg_state)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; IR = 16'h0000; mem_ready = 1'b0; zero = 1'b0;
        tick(); tick();
        settle();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_IR_L",    32'(IR_L), 0);
        chk("rst_state",   32'(dbg_state), 0);

        // Leave reset in FETCH with no memory response.
        rst_n = 1'b1; settle();
        chk("fetch_req",   32'(mem_req), 1);
        chk("fetch_MuxA",  32'(MuxA), 0);
        chk("fetch_stall_IR_L", 32'(IR_L), 0);

        // 1: ALUI 2905 -> rd1 sub01 imm05
        IR = 16'h2905; mem_ready = 1'b1; settle();
        chk("t1_IR_L", 32'(IR_L), 1);
        chk("t1_PS",   32'(PS), 1);
        tick(); mem_ready = 1'b0; settle();
        chk("t1_state_exec", 32'(dbg_state), 1);
        chk("t1_WR",   32'(WR), 1);
        chk("t1_DA",   32'(DA), 1);
        chk("t1_FS",   32'(FS), 1);
        chk("t1_Cin",  32'(Cin), 1);
        chk("t1_K",    32'(K), 32'h0005);
        chk("t1_MuxD", 32'(MuxD), 0);
        chk("t1_exec_req", 32'(mem_req), 0);
        tick(); settle();
        chk("t1_back_fetch", 32'(dbg_state), 0);

        // 2: LOAD 6A40 -> rd2 rs2, three stall cycles in MEM
        IR = 16'h6A40; mem_ready = 1'b1; settle();
        chk("t2_IR_L", 32'(IR_L), 1);
        tick(); settle();
        chk("t2_exec", 32'(dbg_state), 1);
        chk("t2_exec_WR", 32'(WR), 0);
        chk("t2_K_zero", 32'(K), 0);
        tick(); mem_ready = 1'b0; settle();
        for (int i = 0; i < 3; i++) begin
            chk("t2_mem_state", 32'(dbg_state), 2);
            chk("t2_mem_req",   32'(mem_req), 1);
            chk("t2_mem_MuxA",  32'(MuxA), 1);
            chk("t2_mem_WR_stall", 32'(WR), 0);
            chk("t2_BA", 32'(BA), 2);
            tick(); settle();
        end
        mem_ready = 1'b1; settle();
        chk("t2_WR_ready",   32'(WR), 1);
        chk("t2_MuxD_ready", 32'(MuxD), 1);
        chk("t2_DA", 32'(DA), 2);
        tick(); settle();
        chk("t2_back_fetch", 32'(dbg_state), 0);
        chk("t2_WR_after", 32'(WR), 0);

        // 3: BRZ imm FE, taken then not taken
        IR = 16'hA0FE; mem_ready = 1'b1; zero = 1'b1; settle();
        tick(); settle();
        chk("t3_PS_taken", 32'(PS), 2);
        chk("t3_K_sext",   32'(K), 32'hFFFE);
        tick(); zero = 1'b0; settle();
        chk("t3_fetch", 32'(dbg_state), 0);
        tick(); settle();
        chk("t3_PS_not_taken", 32'(PS), 0);

        // JMP: PS=11
        tick(); IR = 16'hC003; settle();
        tick(); settle();
        chk("jmp_PS", 32'(PS), 3);
        chk("jmp_K",  32'(K), 32'h0003);

        // 4: STORE with ready in MEM -> single MemWrite pulse
        tick(); IR = 16'h8000; settle();
        tick(); settle();
        chk("t4_exec_MemWrite", 32'(MemWrite), 0);
        tick(); settle();
        chk("t4_mem_state", 32'(dbg_state), 2);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            if (MemWrite) pulses++;
            if (i == 1) IR = 16'hE000;
            tick(); settle();
        end
        chk("t4_one_pulse", 32'(pulses), 1);
        chk("t4_halt_state", 32'(dbg_state), 3);
        chk("t4_halted", 32'(halted), 1);
        tick(); tick(); settle();
        chk("t4_halt_sticky", 32'(halted), 1);
        chk("t4_halt_no_req", 32'(mem_req), 0);

        // 5: reset during a MEM stall
        rst_n = 1'b0; tick(); rst_n = 1'b1; IR = 16'h6A40; mem_ready = 1'b1; settle();
        chk("t5_fetch_after_rst", 32'(dbg_state), 0);
        tick(); tick(); mem_ready = 1'b0; settle();
        chk("t5_mem_wait_req", 32'(mem_req), 1);
        rst_n = 1'b0; settle();
        chk("t5_rst_req",  32'(mem_req), 0);
        chk("t5_rst_MuxA", 32'(MuxA), 0);
        chk("t5_rst_WR",   32'(WR), 0);
        tick(); settle();
        chk("t5_rst_state", 32'(dbg_state), 0);
        chk("t5_rst_req2",  32'(mem_req), 0);
        rst_n = 1'b1; settle();
        chk("t5_release_state", 32'(dbg_state), 0);
        chk("t5_release_req",   32'(mem_req), 1);

`ifdef MEM_TIMEOUT_EN
        // 6a: fifteen stalled FETCH cycles -> FAULT
        for (int i = 0; i < 15; i++) begin
            chk("t6_no_fault_yet", 32'(fault), 0);
            tick(); settle();
        end
        chk("t6_fault", 32'(fault), 1);
        chk("t6_fault_state", 32'(dbg_state), 4);
        chk("t6_fault_no_req", 32'(mem_req), 0);
        // 6b: ready on the 15th cycle completes normally
        rst_n = 1'b0; tick(); rst_n = 1'b1; IR = 16'h0000; settle();
        for (int i = 0; i < 14; i++) begin
            tick(); settle();
        end
        mem_ready = 1'b1; settle();
        chk("t6_ready_15_IR_L", 32'(IR_L), 1);
        tick(); settle();
        chk("t6_ready_15_exec", 32'(dbg_state), 1);
        chk("t6_ready_15_no_fault", 32'(fault), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
